register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: register width and data port width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2^ADDR_W (32 registers).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 read_reg1  input  ADDR_W  address for read port 1; its data feeds the ALU/NOR first operand.
REQ-006 read_reg2  input  ADDR_W  address for read port 2; its data feeds the ALU/NOR second operand.
REQ-007 write_reg  input  ADDR_W  destination address for the write port.
REQ-008 write_data  input  DATA_W  data to write.
REQ-009 reg_write  input  1  write enable, sampled on the rising clk edge.
REQ-010 clear_req  input  1  one-cycle pulse that starts a sequential clear of all registers.
REQ-011 read_data1  output  DATA_W  combinational read data for read_reg1.
REQ-012 read_data2  output  DATA_W  combinational read data for read_reg2.
REQ-013 busy  output  1  high while the clear sequence runs.
REQ-014 clear_done  output  1  one-cycle pulse in the cycle after the last register is cleared.

Function
REQ-015 Register 0 SHALL always read as 0; writes to address 0 are discarded.
REQ-016 When reg_write=1, busy=0 and write_reg!=0, mem[write_reg] SHALL take write_data at the rising edge; the written value is architecturally visible on the following cycle.
REQ-017 Same-cycle bypass: if reg_write=1, busy=0, write_reg!=0 and read_regN==write_reg, read_dataN SHALL equal write_data combinationally in that cycle.
REQ-018 Otherwise read_dataN SHALL equal mem[read_regN] combinationally, with zero cycles of latency.
REQ-019 Both read ports SHALL operate independently; read_reg1==read_reg2 returns identical data on both ports.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR, with a clear counter clr_ptr of width ADDR_W.
REQ-021 IDLE->CLEAR when clear_req=1; clr_ptr SHALL load 1 and busy SHALL be 1 starting the next cycle.
REQ-022 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr] and then increment clr_ptr.
REQ-023 In CLEAR with clr_ptr==2^ADDR_W-1, the FSM SHALL clear that register and return to IDLE, and clear_done SHALL be 1 in the following cycle.
REQ-024 A full clear SHALL take 31 busy cycles (for ADDR_W=5), and the counter SHALL never wrap to 0.
REQ-025 While busy=1, reg_write SHALL be ignored (no write, no bypass), and reads SHALL return current mem contents.
REQ-026 If a write and clear_req occur in the same IDLE cycle, the write SHALL commit and the clear SHALL start.
REQ-027 clear_req while busy=1 SHALL be ignored; the running sequence continues and is not restarted.
REQ-028 Out-of-range addresses cannot occur, because all 2^ADDR_W addresses are valid.

Reset
REQ-029 When reset=1 at a rising edge, all registers SHALL become 0, the FSM SHALL go to IDLE, clr_ptr SHALL become 0, busy SHALL be 0 and clear_done SHALL be 0.
REQ-030 Reset SHALL take priority over reg_write, clear_req and an in-progress CLEAR, aborting the sequence with no clear_done pulse.
REQ-031 After reset, read_data1 and read_data2 SHALL be 0 for any address until a write occurs.

Verification
REQ-032 Basic write/read: reset, then write 0xDEADBEEF to r5; the next cycle, read_reg1=5 -> read_data1=0xDEADBEEF; read_reg2=6 -> 0.
REQ-033 $zero: write 0xFFFFFFFF to r0 with read_reg1=0 in the same cycle and in the next cycle -> read_data1=0 both times.
REQ-034 Bypass: reg_write=1, write_reg=7, write_data=0x12345678, read_reg1=read_reg2=7 -> both ports read 0x12345678 in the same cycle.
REQ-035 Clear: fill r1..r31 with their own index, pulse clear_req -> busy is high for exactly 31 cycles, clear_done pulses once, then all registers read 0.
REQ-036 Write during clear: with busy=1, write 0xAAAA5555 to r3 -> the value is ignored and r3 reads 0 after clear_done.
REQ-037 Reset mid-clear: assert reset when busy=1 and clr_ptr=10 -> the next cycle busy=0, there is no clear_done pulse, and all registers read 0.

Source files
------------

// File: rtl/register_file_if.sv
// Register file bus: read/write ports plus the clear handshake.
//   master : drives addresses, write data/enable and clear_req; observes read data and status
//   slave  : the register file itself
interface register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic              clear_req;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              busy;
    logic              clear_done;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write, clear_req,
        input  read_data1, read_data2, busy, clear_done
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write, clear_req,
        output read_data1, read_data2, busy, clear_done
    );
endinterface

// File: rtl/register_file.sv
// Two-read / one-write register file with hardwired zero register, same-cycle write
// bypass and a sequential clear engine.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; zeroes every register and aborts a running clear
//   bus   : register_file_if slave port
//           read_reg1/2 -> read_data1/2 (combinational), write_reg/write_data/reg_write,
//           clear_req pulse starts a clear; busy while clearing; clear_done pulses after it
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic            clk,
    input logic            reset,
    register_file_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastPtr  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FirstPtr = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem [Depth];
    logic              wr_en;

    // Writes only take effect (and bypass) while idle and not aimed at r0.
    assign wr_en = (state_q == StIdle) && bus.reg_write && (bus.write_reg != '0);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.clear_req) begin
                    state_d   = StClear;
                    clr_ptr_d = FirstPtr;  // r0 is already zero, start at r1
                end
            end
            StClear: begin
                if (clr_ptr_q == LastPtr) begin
                    // Pointer is held, never wraps to 0.
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            clr_ptr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == StClear) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            mem[bus.write_reg] <= bus.write_data;
        end
    end

    always_comb begin
        if (wr_en && (bus.read_reg1 == bus.write_reg)) begin
            bus.read_data1 = bus.write_data;
        end else if (bus.read_reg1 == '0) begin
            bus.read_data1 = '0;
        end else begin
            bus.read_data1 = mem[bus.read_reg1];
        end
    end

    always_comb begin
        if (wr_en && (bus.read_reg2 == bus.write_reg)) begin
            bus.read_data2 = bus.write_data;
        end else if (bus.read_reg2 == '0) begin
            bus.read_data2 = '0;
        end else begin
            bus.read_data2 = mem[bus.read_reg2];
        end
    end

    assign bus.busy       = (state_q == StClear);
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: randomized traffic against a behavioural model.
module tb_register_file;
    localparam int DataW = 32;
    localparam int AddrW = 5;
    localparam int Depth = 32;
    localparam int ClearLen = 31;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    register_file_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

    register_file #(.DATA_W(DataW), .ADDR_W(AddrW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register contents, how many cycles into a clear we are (0 = idle),
    // and whether clear_done is due this cycle.
    logic [DataW-1:0] ref_mem [Depth];
    int               ref_phase;
    logic             ref_done;

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
            ref_phase = 0;
            ref_done  = 1'b0;
        end else begin
            ref_done = (ref_phase == ClearLen);
            if (ref_phase != 0) begin
                // During clear cycle k, register k gets zeroed.
                ref_mem[ref_phase] = '0;
                ref_phase = (ref_phase == ClearLen) ? 0 : ref_phase + 1;
            end else begin
                if (bus.reg_write && bus.write_reg != 0) ref_mem[bus.write_reg] = bus.write_data;
                if (bus.clear_req) ref_phase = 1;
            end
        end
    endtask

    function automatic logic [DataW-1:0] exp_rd(input logic [AddrW-1:0] a);
        if (ref_phase == 0 && bus.reg_write && bus.write_reg != 0 && a == bus.write_reg)
            return bus.write_data;
        return (a == 0) ? '0 : ref_mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bus.reg_write = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    task automatic fill_index();
        for (int i = 1; i < Depth; i++) begin
            bus.reg_write  = 1'b1;
            bus.write_reg  = AddrW'(i);
            bus.write_data = DataW'(i);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.reg_write = 1'b1; bus.write_reg = 5'd4; bus.write_data = 32'h5a5a_0001;
        bus.clear_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b done=%b want 0 0", bus.busy, bus.clear_done);
        end
        for (int i = 0; i < 8; i++) begin
            bus.read_reg1 = AddrW'($urandom_range(0, Depth - 1));
            bus.read_reg2 = AddrW'($urandom_range(0, Depth - 1));
            #1;
            n_checks++;
            if (bus.read_data1 !== '0 || bus.read_data2 !== '0) begin
                n_errors++;
                $display("FAIL reset_read: rd1=%h rd2=%h want 0", bus.read_data1, bus.read_data2);
            end
        end
    endtask

    task automatic test_basic();
        bus.reg_write = 1'b1; bus.write_reg = 5'd5; bus.write_data = 32'hDEAD_BEEF;
        tick();
        drive_idle();
        bus.read_reg1 = 5'd5; bus.read_reg2 = 5'd6;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'hDEAD_BEEF || bus.read_data2 !== 32'h0) begin
            n_errors++;
            $display("FAIL basic_rw: rd1=%h rd2=%h want deadbeef 0",
                     bus.read_data1, bus.read_data2);
        end
    endtask

    task automatic test_zero();
        bus.reg_write = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'hFFFF_FFFF;
        bus.read_reg1 = 5'd0;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_errors++;
            $display("FAIL zero_same_cycle: rd1=%h want 0", bus.read_data1);
        end
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_errors++;
            $display("FAIL zero_next_cycle: rd1=%h want 0", bus.read_data1);
        end
    endtask

    task automatic test_bypass();
        bus.reg_write = 1'b1; bus.write_reg = 5'd7; bus.write_data = 32'h1234_5678;
        bus.read_reg1 = 5'd7; bus.read_reg2 = 5'd7;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h1234_5678 || bus.read_data2 !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL bypass: rd1=%h rd2=%h want 12345678", bus.read_data1, bus.read_data2);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bus.reg_write  = 1'($urandom_range(0, 1));
            bus.write_reg  = AddrW'($urandom_range(0, Depth - 1));
            bus.write_data = $urandom;
            bus.read_reg1  = AddrW'($urandom_range(0, Depth - 1));
            bus.read_reg2  = ($urandom_range(0, 3) == 0) ? bus.read_reg1 :
                             AddrW'($urandom_range(0, Depth - 1));
            if ($urandom_range(0, 3) == 0) bus.read_reg1 = bus.write_reg;
            #1;
            n_checks++;
            if (bus.read_data1 !== exp_rd(bus.read_reg1) ||
                bus.read_data2 !== exp_rd(bus.read_reg2) || bus.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL random_rw: rd1=%h rd2=%h busy=%b want %h %h 0",
                         bus.read_data1, bus.read_data2, bus.busy,
                         exp_rd(bus.read_reg1), exp_rd(bus.read_reg2));
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        fill_index();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            bus.read_reg1 = AddrW'($urandom_range(0, Depth - 1));
            bus.read_reg2 = AddrW'(ref_phase);
            #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clear_done === 1'b1) done_cnt++;
            n_checks++;
            if (bus.busy !== (ref_phase != 0) || bus.clear_done !== ref_done ||
                bus.read_data1 !== exp_rd(bus.read_reg1) ||
                bus.read_data2 !== exp_rd(bus.read_reg2)) begin
                n_errors++;
                $display("FAIL clear_progress: c=%0d busy=%b done=%b rd1=%h rd2=%h want %b %b %h %h",
                         c, bus.busy, bus.clear_done, bus.read_data1, bus.read_data2,
                         ref_phase != 0, ref_done, exp_rd(bus.read_reg1), exp_rd(bus.read_reg2));
            end
            tick();
        end
        n_checks++;
        if (busy_cnt != ClearLen || done_cnt != 1) begin
            n_errors++;
            $display("FAIL clear_length: busy_cycles=%0d done_pulses=%0d want 31 1",
                     busy_cnt, done_cnt);
        end
        for (int i = 0; i < Depth; i++) begin
            bus.read_reg1 = AddrW'(i);
            bus.read_reg2 = AddrW'(Depth - 1 - i);
            #1;
            n_checks++;
            if (bus.read_data1 !== '0 || bus.read_data2 !== '0) begin
                n_errors++;
                $display("FAIL clear_result: r%0d=%h want 0", i, bus.read_data1);
            end
        end
    endtask

    task automatic test_write_during_clear();
        fill_index();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        while (ref_phase != 5) tick();
        bus.reg_write = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'hAAAA_5555;
        bus.read_reg1 = 5'd3; bus.read_reg2 = 5'd20;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'd20) begin
            n_errors++;
            $display("FAIL busy_no_bypass: rd1=%h rd2=%h want 0 14", bus.read_data1, bus.read_data2);
        end
        tick();
        drive_idle();
        for (int c = 0; c < 40 && bus.clear_done !== 1'b1; c++) tick();
        n_checks++;
        if (bus.clear_done !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_write_done: clear_done=%b want 1", bus.clear_done);
        end
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_errors++;
            $display("FAIL busy_write_ignored: r3=%h want 0", bus.read_data1);
        end
    endtask

    task automatic test_write_with_clear();
        bus.reg_write = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h0000_CAFE;
        bus.clear_req = 1'b1;
        tick();
        drive_idle();
        bus.read_reg1 = 5'd9;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.read_data1 !== 32'h0000_CAFE) begin
            n_errors++;
            $display("FAIL write_and_clear: busy=%b r9=%h want 1 0000cafe", bus.busy, bus.read_data1);
        end
        // A second clear_req mid-sequence must not restart the count.
        while (ref_phase != 5) tick();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int c = 0; c < 40 && bus.clear_done !== 1'b1; c++) tick();
        n_checks++;
        if (bus.clear_done !== 1'b1 || ref_done !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_req_ignored: clear_done=%b want 1 at model cycle", bus.clear_done);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.read_data1 !== 32'h0) begin
            n_errors++;
            $display("FAIL after_clear: busy=%b done=%b r9=%h want 0 0 0",
                     bus.busy, bus.clear_done, bus.read_data1);
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_seen;
        fill_index();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        while (ref_phase != 10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abort: busy=%b done=%b want 0 0", bus.busy, bus.clear_done);
        end
        done_seen = 0;
        for (int i = 0; i < Depth; i++) begin
            bus.read_reg1 = AddrW'(i);
            bus.read_reg2 = AddrW'(i);
            #1;
            if (bus.clear_done === 1'b1) done_seen++;
            n_checks++;
            if (bus.read_data1 !== '0 || bus.read_data2 !== '0) begin
                n_errors++;
                $display("FAIL reset_abort_read: r%0d=%h want 0", i, bus.read_data1);
            end
            tick();
        end
        n_checks++;
        if (done_seen != 0) begin
            n_errors++;
            $display("FAIL reset_abort_done: done_pulses=%0d want 0", done_seen);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ref_phase = 0;
        ref_done = 1'b0;
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
        reset = 1'b1;
        bus.read_reg1 = '0; bus.read_reg2 = '0;
        bus.write_reg = '0; bus.write_data = '0;
        bus.reg_write = 1'b0; bus.clear_req = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_random();
        test_clear();
        test_random();
        test_write_during_clear();
        test_write_with_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
